imem_refill_engine: RTL
=======================

# imem_refill_engine

Memory-side refill engine for the instruction cache. On a miss the icache controller asserts memRen with BlockAddr. This block then fetches the block one word at a time over a word-wide, single-outstanding main-memory bus and assembles the words into a full block. It presents the block on memDout with a one-cycle memReadReady pulse. It sits directly downstream of the icache controller and upstream of the instruction memory or bus.

## Interface
Parameters:
- WORD_BITS, default `IWORD_SIZE_BITS (32): width of one bus word.
- BLOCK_WORDS, default `IBLOCK_SIZE_BITS/`IWORD_SIZE_BITS (4): beats per block; must be a power of two and at least 2.
- ADDR_BITS, default `IADDR_SIZE (32): byte-address width of the bus.
- BLK_ADDR_BITS, default `IMEM_BLOCK_ADDR_SIZE (28): block-address width.

Ports:
- clock, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- memRen, input, 1: refill request from the icache controller; level, held while it waits.
- BlockAddr, input, BLK_ADDR_BITS: block to fetch; sampled in the IDLE→REQ cycle.
- memReadReady, output, 1: one-cycle pulse; the block is complete on memDout.
- memDout, output, BLOCK_WORDS*WORD_BITS: assembled block; word i occupies bits [i*WORD_BITS +: WORD_BITS].
- busy, output, 1: high in any state other than IDLE.
- bus_req, output, 1: word read request.
- bus_addr, output, ADDR_BITS: byte address of the requested word.
- bus_ready, input, 1: the bus accepts the request when bus_req && bus_ready.
- bus_rvalid, input, 1: read data valid.
- bus_rdata, input, WORD_BITS: read data.

## Operation
FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, memRen=1: latch BlockAddr into blk_q, clear beat to 0, go to REQ. Otherwise stay in IDLE.
- REQ: bus_req=1 and bus_addr={blk_q, beat, `IWORD_OFFSET_SIZE'b0}.
  - bus_ready=1: go to WAIT.
  - bus_ready=0: stay in REQ with bus_req and bus_addr held stable.
- WAIT: bus_rvalid=1 writes bus_rdata into memDout word [beat].
  - If beat==BLOCK_WORDS-1, go to DONE.
  - Otherwise beat+1 and go to REQ.
- DONE: memReadReady=1 for exactly this cycle, then go to IDLE.
- Beat order is linear, word 0 first; there is no critical-word-first.
- memDout holds its last value from DONE until overwritten by beat 0 of the next refill. This covers the controller's cache-write cycle that follows memReadReady.
- bus_rvalid is ignored outside WAIT. At most one request is outstanding at a time.
- memRen dropping during REQ or WAIT aborts the refill:
  - An outstanding accepted beat is still completed. WAIT waits for its bus_rvalid and discards the data.
  - The FSM then returns to IDLE with no memReadReady pulse.
  - REQ with bus_ready=0 returns to IDLE immediately.
- memRen still high in the cycle after DONE starts a new refill of the currently presented BlockAddr. This is legal.
- The beat counter is log2(BLOCK_WORDS) bits wide. Incrementing from the last beat never occurs because the FSM exits to DONE.
- Reset, including mid-refill: state=IDLE, beat=0, blk_q=0.
  - Outputs: memReadReady=0, memDout=0, bus_req=0, bus_addr=0, busy=0.
  - Any in-flight bus response is ignored.

## Timing
- bus_req and memReadReady are decoded from registered state and carry no combinational path from inputs. bus_addr is decoded from the blk_q and beat registers.
- memRen seen high at edge 0 gives the first bus_req in cycle 1.
- Best-case per-beat cost is 2 cycles: REQ with bus_ready=1, then bus_rvalid in the next cycle.
- Best-case refill: memReadReady in cycle 2*BLOCK_WORDS+1 after the sampling edge (cycle 9 for 4 words).
- Each cycle of bus_ready low or bus_rvalid late adds exactly one cycle.
- memDout word [beat] updates on the edge that samples bus_rvalid.

## Structure
- Shared constants come from include/constants.vh: `IWORD_SIZE_BITS, `IBLOCK_SIZE_BITS, `IADDR_SIZE, `IBLOCK_OFFSET_SIZE, `IWORD_OFFSET_SIZE, `IMEM_BLOCK_ADDR_SIZE.
- State encodings are local parameters: IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DONE=2'b11.
- One sub-module, imem_beat_counter: a parameterised up-counter with clear and enable and asynchronous active-high reset.

## Test plan
- Basic refill: BLOCK_WORDS=4, BlockAddr=28'h0000040, bus_ready always 1, rvalid one cycle after each accept, data 32'h11111111..32'h44444444.
  - Required: bus_addr sequence 0x400, 0x404, 0x408, 0x40C.
  - Required: memDout=128'h44444444_33333333_22222222_11111111.
  - Required: a single memReadReady pulse in cycle 9.
- Backpressure: bus_ready low for 3 cycles on beat 1, and rvalid delayed 2 extra cycles on beat 2.
  - Required: bus_addr is held 0x404 while stalled.
  - Required: memReadReady arrives 5 cycles later than in the basic case, with correct data.
- Abort: memRen dropped in WAIT of beat 1.
  - Required: beat 1 response is consumed and discarded, the FSM returns to IDLE, and there is no memReadReady.
  - Required: a following refill of 28'h0000080 issues 0x800 first.
- Reset mid-refill: assert reset in WAIT of beat 2.
  - Required: all outputs are 0 in the same cycle, and a late bus_rvalid is ignored.
  - Required: a new refill completes normally.
- Back-to-back: memRen held high through DONE.
  - Required: memDout stays stable for the cycle after memReadReady.
  - Required: a second refill starts with bus_req in the following cycle.

Source files
------------

// File: rtl/imem_refill_engine_pkg.sv
// Shared constants and the refill FSM state type for the instruction-memory
// refill engine.
package imem_refill_engine_pkg;

    localparam int IWORD_SIZE_BITS      = 32;
    localparam int IBLOCK_SIZE_BITS     = 128;
    localparam int IADDR_SIZE           = 32;
    localparam int IWORD_OFFSET_SIZE    = 2;
    localparam int IMEM_BLOCK_ADDR_SIZE = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } refillState_e;

endpackage

// File: rtl/imem_refill_engine_beat_counter.sv
// Beat counter for the refill engine. It is a plain up-counter with
// synchronous clear and count enable. Clear has priority over enable.
module imem_beat_counter
    import imem_refill_engine_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count register: cleared at the start of each refill, stepped once per captured beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/imem_refill_engine.sv
// Instruction-cache refill engine. It fetches one block word by word over a
// single-outstanding bus and assembles the words into memDout. Completion is
// signalled with a one-cycle memReadReady pulse.
module imem_refill_engine
    import imem_refill_engine_pkg::*;
#(
    parameter int WORD_BITS     = IWORD_SIZE_BITS,
    parameter int BLOCK_WORDS   = IBLOCK_SIZE_BITS / IWORD_SIZE_BITS,
    parameter int ADDR_BITS     = IADDR_SIZE,
    parameter int BLK_ADDR_BITS = IMEM_BLOCK_ADDR_SIZE
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             memRen,
    input  logic [BLK_ADDR_BITS-1:0]         BlockAddr,
    output logic                             memReadReady,
    output logic [BLOCK_WORDS*WORD_BITS-1:0] memDout,
    output logic                             busy,
    output logic                             bus_req,
    output logic [ADDR_BITS-1:0]             bus_addr,
    input  logic                             bus_ready,
    input  logic                             bus_rvalid,
    input  logic [WORD_BITS-1:0]             bus_rdata
);

    localparam int BEAT_BITS = $clog2(BLOCK_WORDS);
    localparam int CAT_BITS  = BLK_ADDR_BITS + BEAT_BITS + IWORD_OFFSET_SIZE;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BLOCK_WORDS - 1);

    refillState_e                     r_state;
    refillState_e                     w_nextState;
    logic [BLK_ADDR_BITS-1:0]         r_blkQ;
    logic                             r_abort;
    logic [BLOCK_WORDS*WORD_BITS-1:0] r_memDout;
    logic [BEAT_BITS-1:0]             w_beat;
    logic                             w_start;
    logic                             w_abortNow;
    logic                             w_lastBeat;
    logic                             w_capture;
    logic                             w_beatInc;
    logic [CAT_BITS-1:0]              w_addrFull;

    // A refill that was abandoned stays abandoned even if memRen comes back
    // before the outstanding response arrives.
    assign w_start    = (r_state == ST_IDLE) && memRen;
    assign w_abortNow = r_abort || !memRen;
    assign w_lastBeat = (w_beat == LAST_BEAT);
    assign w_capture  = (r_state == ST_WAIT) && bus_rvalid && !w_abortNow;
    assign w_beatInc  = w_capture && !w_lastBeat;

    imem_beat_counter #(
        .WIDTH (BEAT_BITS)
    ) u_beatCounter (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_start),
        .i_enable (w_beatInc),
        .o_count  (w_beat)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: an accepted beat is always drained before an abort returns to idle
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (memRen) begin
                    w_nextState = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    w_nextState = ST_WAIT;
                end else if (w_abortNow) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    if (w_abortNow) begin
                        w_nextState = ST_IDLE;
                    end else if (w_lastBeat) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_nextState = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only, so no input reaches these combinationally
    always_comb begin
        bus_req      = (r_state == ST_REQ);
        memReadReady = (r_state == ST_DONE);
        busy         = (r_state != ST_IDLE);
    end

    // Datapath: block address latch, sticky abort flag and block assembly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blkQ    <= '0;
            r_abort   <= 1'b0;
            r_memDout <= '0;
        end else begin
            if (w_start) begin
                r_blkQ <= BlockAddr;
            end
            if (r_state == ST_IDLE) begin
                r_abort <= 1'b0;
            end else if ((r_state == ST_REQ || r_state == ST_WAIT) && !memRen) begin
                r_abort <= 1'b1;
            end
            if (w_capture) begin
                r_memDout[w_beat*WORD_BITS +: WORD_BITS] <= bus_rdata;
            end
        end
    end

    assign w_addrFull = {r_blkQ, w_beat, {IWORD_OFFSET_SIZE{1'b0}}};
    assign bus_addr   = ADDR_BITS'(w_addrFull);
    assign memDout    = r_memDout;

endmodule
